// File: rtl/cnn_class_argmax.sv
// -----------------------------------------------------------------------------
// cnn_class_argmax
//
// Argmax over one frame of IEEE-754 single-precision class scores coming out
// of the CNN core. A frame is N_CLASS consecutive valid beats. The largest
// score is tracked beat by beat with a single integer comparator, and a
// one-cycle result is produced after the frame ends.
//
// A frame that stops early (in_valid drops before N_CLASS beats) is reported
// as an error: out_err=1 with out_class/out_max forced to 0.
//
// Ordering used by the comparator (no floating-point hardware):
//   NaN < -Inf < negatives < zero < positives < +Inf
//   +0, -0 and all denormals are equal (denormals are treated as zero);
//   any two NaNs are equal. Ties keep the earlier beat.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   score beat valid (CNN out_valid)
//   in_data    score beat, IEEE-754 single bit pattern (CNN out)
//   out_valid  one-cycle result strobe
//   out_class  0-based beat index of the winning score
//   out_max    original bit pattern of the winning score
//   out_err    frame ended with fewer than N_CLASS beats
//
// All result outputs read 0 whenever out_valid is 0.
// -----------------------------------------------------------------------------
module cnn_class_argmax #(
  parameter int N_CLASS = 3,   // beats per frame, legal 2..4
  parameter int DATA_W  = 32   // fixed IEEE-754 single width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [1:0]        out_class,
  output logic [DATA_W-1:0] out_max,
  output logic              out_err
);

  // Beat count value at which the incoming beat is the last one of a frame.
  localparam logic [2:0] LAST_CNT = 3'(N_CLASS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_OUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;        // beats received in the current frame
  logic [DATA_W-1:0] best_val;   // running maximum, original bit pattern
  logic [1:0]        best_idx;   // beat index of best_val
  logic              err_q;      // result held in S_OUT is a short frame
  logic              replace;    // in_data is strictly greater than best_val

  // ---------------------------------------------------------------------------
  // Score comparator: returns 1 when a is strictly greater than b.
  // Non-NaN values are ordered sign-magnitude; zeros and denormals collapse
  // to a single magnitude-0 point with no sign, so +0/-0/denormals tie.
  // ---------------------------------------------------------------------------
  function automatic logic score_gt(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, b_nan;
    logic        a_zero, b_zero;
    logic        a_neg, b_neg;
    logic [30:0] a_mag, b_mag;
    logic        gt;

    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_neg  = a[31] && !a_zero;
    b_neg  = b[31] && !b_zero;
    a_mag  = a_zero ? 31'd0 : a[30:0];
    b_mag  = b_zero ? 31'd0 : b[30:0];

    if (a_nan) begin
      gt = 1'b0;                       // NaN is never greater than anything
    end else if (b_nan) begin
      gt = 1'b1;                       // any number beats NaN
    end else if (a_neg != b_neg) begin
      gt = b_neg;                      // non-negative beats negative
    end else if (a_neg) begin
      gt = (a_mag < b_mag);            // both negative: smaller magnitude wins
    end else begin
      gt = (a_mag > b_mag);            // both non-negative
    end
    return gt;
  endfunction

  assign replace = score_gt(in_data, best_val);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (!in_valid) begin
          state_nxt = S_OUT;             // short frame
        end else if (cnt == LAST_CNT) begin
          state_nxt = S_OUT;             // last beat of a full frame
        end
      end
      S_OUT: begin
        // A beat arriving while the result is shown starts the next frame.
        state_nxt = in_valid ? S_COLLECT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame datapath: beat counter, running best and error flag.
  // While in S_OUT the best registers still hold the finished frame; they are
  // only overwritten at the edge that leaves S_OUT, so the result shown during
  // S_OUT is never disturbed by a back-to-back beat 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 3'd0;
      best_val <= '0;
      best_idx <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_OUT: begin
          if (in_valid) begin
            best_val <= in_data;
            best_idx <= 2'd0;
            cnt      <= 3'd1;
          end else begin
            cnt      <= 3'd0;
          end
        end
        S_COLLECT: begin
          if (in_valid) begin
            if (replace) begin
              best_val <= in_data;
              best_idx <= cnt[1:0];
            end
            cnt   <= cnt + 3'd1;
            err_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: begin
          cnt   <= 3'd0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state, so they are glitch-free and drop
  // to 0 as soon as reset is asserted.
  // ---------------------------------------------------------------------------
  assign out_valid = (state == S_OUT);
  assign out_err   = out_valid && err_q;
  assign out_class = (out_valid && !err_q) ? best_idx : 2'd0;
  assign out_max   = (out_valid && !err_q) ? best_val : '0;

endmodule

// File: tb/tb_cnn_class_argmax.sv
// -----------------------------------------------------------------------------
// tb_cnn_class_argmax
//
// Self-checking bench for cnn_class_argmax (N_CLASS=3):
//   - reset values
//   - table of directed 3-beat frames (ordering, ties, NaN, denormals)
//   - short frame, back-to-back frames, reset in mid-frame and during a result
//   - random beat stream checked cycle by cycle against a frame-level model
//     that splits the stream into frames and ranks scores by a numeric key
// Inputs change after the falling edge; outputs are sampled on the falling
// edge, i.e. half a cycle after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_cnn_class_argmax;

  localparam int N = 3;
  localparam int L = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [1:0]  out_class;
  logic [31:0] out_max;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  cnn_class_argmax #(.N_CLASS(N), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_class (out_class),
    .out_max   (out_max),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0][31:0] beats;
    logic [1:0]       cls;
    logic [31:0]      mx;
  } vec_t;

  vec_t vecs[8];

  // random stream and expected outputs after each rising edge
  logic        rv[L];
  logic [31:0] rd[L];
  logic        ev[L];
  logic [1:0]  ec[L];
  logic [31:0] em[L];
  logic        ee[L];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    tick();
  endtask

  task automatic check_result(input string name, input logic v, input logic [1:0] c,
                              input logic [31:0] m, input logic e);
    check({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({name, "_class"}, {30'd0, out_class}, {30'd0, c});
    check({name, "_max"},   out_max, m);
    check({name, "_err"},   {31'd0, out_err}, {31'd0, e});
  endtask

  function automatic vec_t mk(input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [1:0] c,
                              input logic [31:0] m);
    vec_t r;
    r.beats[0] = b0;
    r.beats[1] = b1;
    r.beats[2] = b2;
    r.cls      = c;
    r.mx       = m;
    return r;
  endfunction

  // Numeric rank of a score: NaN lowest, zeros/denormals 0, else signed magnitude.
  function automatic longint rank(input logic [31:0] x);
    longint mag;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return -64'sd1099511627776;
    if (x[30:23] == 8'h00) return 0;
    mag = longint'({33'd0, x[30:0]});
    return x[31] ? -mag : mag;
  endfunction

  function automatic int argmax(input logic [31:0] q[$]);
    int best = 0;
    for (int i = 1; i < q.size(); i++)
      if (rank(q[i]) > rank(q[best])) best = i;
    return best;
  endfunction

  function automatic logic [31:0] rand_score();
    logic [31:0] r;
    case ($urandom_range(0, 9))
      0: r = {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};        // NaN
      1: r = {1'($urandom), 8'hFF, 23'd0};                         // +/-Inf
      2: r = {1'($urandom), 31'd0};                                // +/-0
      3: r = {1'($urandom), 8'h00, 23'($urandom) | 23'd1};        // denormal
      4, 5: r = {1'($urandom), 8'h7F + 8'($urandom_range(0, 1)),
                 23'($urandom_range(0, 3))};                       // close values, ties
      default: r = $urandom;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] q[$];
    int t;
    int w;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;

    vecs[0] = mk(32'h3F800000, 32'h40000000, 32'h3F000000, 2'd1, 32'h40000000);
    vecs[1] = mk(32'hBF800000, 32'hC0400000, 32'hBF000000, 2'd2, 32'hBF000000);
    vecs[2] = mk(32'h80000000, 32'h00000000, 32'h00000001, 2'd0, 32'h80000000);
    vecs[3] = mk(32'h7FC00000, 32'hFF800000, 32'h7FC00000, 2'd1, 32'hFF800000);
    vecs[4] = mk(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 2'd0, 32'h7FC00000);
    vecs[5] = mk(32'h3F800000, 32'h7F800000, 32'h7F800000, 2'd1, 32'h7F800000);
    vecs[6] = mk(32'hC0000000, 32'h807FFFFF, 32'hBF800000, 2'd1, 32'h807FFFFF);
    vecs[7] = mk(32'hFF800000, 32'hFFFFFFFF, 32'hFF7FFFFF, 2'd2, 32'hFF7FFFFF);

    // ---------------- reset state ----------------
    #1;
    check_result("reset", 1'b0, 2'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'd0);
    check_result("post_reset_idle", 1'b0, 2'd0, 32'd0, 1'b0);

    // ---------------- directed frame table ----------------
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < N; j++) begin
        drive(1'b1, vecs[i].beats[j]);
        if (j < N - 1)
          check($sformatf("vec%0d_beat%0d_valid", i, j), {31'd0, out_valid}, 32'd0);
      end
      check_result($sformatf("vec%0d", i), 1'b1, vecs[i].cls, vecs[i].mx, 1'b0);
      drive(1'b0, 32'd0);
      check_result($sformatf("vec%0d_after", i), 1'b0, 2'd0, 32'd0, 1'b0);
    end

    // ---------------- short frame ----------------
    drive(1'b1, 32'h3F800000);
    drive(1'b1, 32'h40000000);
    check("short_pre_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 32'd0);
    check_result("short", 1'b1, 2'd0, 32'd0, 1'b1);
    drive(1'b0, 32'd0);
    check_result("short_idle", 1'b0, 2'd0, 32'd0, 1'b0);
    drive(1'b1, 32'h3F000000);
    drive(1'b1, 32'h3F800000);
    drive(1'b1, 32'h3F400000);
    check_result("after_short", 1'b1, 2'd1, 32'h3F800000, 1'b0);
    drive(1'b0, 32'd0);

    // ---------------- back-to-back frames ----------------
    drive(1'b1, 32'h3F800000);
    drive(1'b1, 32'h40000000);
    drive(1'b1, 32'h3F000000);
    check_result("b2b_first", 1'b1, 2'd1, 32'h40000000, 1'b0);
    drive(1'b1, 32'h7F800000);
    check_result("b2b_gap", 1'b0, 2'd0, 32'd0, 1'b0);
    drive(1'b1, 32'h00000000);
    check_result("b2b_gap2", 1'b0, 2'd0, 32'd0, 1'b0);
    drive(1'b1, 32'h3F800000);
    check_result("b2b_second", 1'b1, 2'd0, 32'h7F800000, 1'b0);
    drive(1'b0, 32'd0);
    check_result("b2b_idle", 1'b0, 2'd0, 32'd0, 1'b0);

    // ---------------- reset mid-frame ----------------
    drive(1'b1, 32'h40400000);
    drive(1'b1, 32'h40800000);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_result("rst_mid", 1'b0, 2'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'd0);
      check_result($sformatf("rst_mid_quiet%0d", k), 1'b0, 2'd0, 32'd0, 1'b0);
    end
    drive(1'b1, 32'hBF800000);
    drive(1'b1, 32'h3F000000);
    drive(1'b1, 32'h3E800000);
    check_result("rst_mid_next", 1'b1, 2'd1, 32'h3F000000, 1'b0);

    // reset while a result is on the outputs: outputs must clear at once
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_result("rst_in_out", 1'b0, 2'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'd0);
    check_result("rst_in_out_quiet", 1'b0, 2'd0, 32'd0, 1'b0);
    drive(1'b1, 32'h00000000);
    drive(1'b1, 32'h80000000);
    drive(1'b1, 32'hC1000000);
    check_result("rst_in_out_next", 1'b1, 2'd0, 32'h00000000, 1'b0);
    drive(1'b0, 32'd0);

    // ---------------- random stream vs frame-level model ----------------
    for (int e = 0; e < L; e++) begin
      rv[e] = (e < L - 5) ? ($urandom_range(0, 7) != 0) : 1'b0;
      rd[e] = rand_score();
      ev[e] = 1'b0;
      ec[e] = 2'd0;
      em[e] = 32'd0;
      ee[e] = 1'b0;
    end
    t = 0;
    while (t < L) begin
      if (!rv[t]) begin
        t++;
        continue;
      end
      q.delete();
      q.push_back(rd[t]);
      t++;
      while (t < L && rv[t] && q.size() < N) begin
        q.push_back(rd[t]);
        t++;
      end
      if (q.size() == N) begin
        w = argmax(q);
        ev[t-1] = 1'b1;
        ec[t-1] = 2'(w);
        em[t-1] = q[w];
      end else if (t < L) begin
        ev[t] = 1'b1;
        ee[t] = 1'b1;
        t++;
      end
    end
    for (int e = 0; e < L; e++) begin
      drive(rv[e], rd[e]);
      check_result($sformatf("rnd%0d", e), ev[e], ec[e], em[e], ee[e]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
